// File: rtl/seq_pkg.sv
// seq_pkg: shared state encoding and sizing helper for the serial pattern generator
package seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2
   } seq_state_e;

   function automatic int idx_bits(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/seq_gen.sv
// seq_gen: bursts a fixed bit pattern MSB first, repeated with optional idle gaps
module seq_gen
   import seq_pkg::*;
#(
   parameter int               WIDTH = 5,
   parameter logic [WIDTH-1:0] SEQ   = 5'b10010,
   parameter int               CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [CNT_W-1:0] repeat_n,
   input  logic [CNT_W-1:0] gap,
   input  logic             abort,
   output logic             out,
   output logic             out_valid,
   output logic             busy,
   output logic             done
);

   localparam int            IW      = idx_bits(WIDTH);
   localparam logic [IW-1:0] IDX_TOP = IW'(WIDTH - 1);

   seq_state_e       state_q;
   logic [IW-1:0]    idx_q;
   logic [CNT_W-1:0] rep_q;
   logic [CNT_W-1:0] gap_q;
   logic [CNT_W-1:0] gcnt_q;
   logic             out_q;
   logic             valid_q;
   logic             busy_q;
   logic             done_q;

   // idx_q is the index of the bit currently on out; rep_q counts repetitions left including the current one
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         rep_q   <= '0;
         gap_q   <= '0;
         gcnt_q  <= '0;
         out_q   <= 1'b0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start && !abort && repeat_n != '0) begin
                  state_q <= SEND;
                  rep_q   <= repeat_n;
                  gap_q   <= gap;
                  idx_q   <= IDX_TOP;
                  out_q   <= SEQ[WIDTH-1];
                  valid_q <= 1'b1;
                  busy_q  <= 1'b1;
               end
            end
            SEND: begin
               if (abort) begin
                  state_q <= IDLE;
                  out_q   <= 1'b0;
                  valid_q <= 1'b0;
                  busy_q  <= 1'b0;
               end else if (idx_q != '0) begin
                  idx_q <= idx_q - 1'b1;
                  out_q <= SEQ[idx_q - 1'b1];
               end else if (rep_q == CNT_W'(1)) begin
                  state_q <= IDLE;
                  out_q   <= 1'b0;
                  valid_q <= 1'b0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else if (gap_q == '0) begin
                  rep_q <= rep_q - CNT_W'(1);
                  idx_q <= IDX_TOP;
                  out_q <= SEQ[WIDTH-1];
               end else begin
                  rep_q   <= rep_q - CNT_W'(1);
                  state_q <= GAP;
                  gcnt_q  <= gap_q;
                  out_q   <= 1'b0;
                  valid_q <= 1'b0;
               end
            end
            GAP: begin
               if (abort) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end else if (gcnt_q == CNT_W'(1)) begin
                  state_q <= SEND;
                  idx_q   <= IDX_TOP;
                  out_q   <= SEQ[WIDTH-1];
                  valid_q <= 1'b1;
               end else begin
                  gcnt_q <= gcnt_q - CNT_W'(1);
               end
            end
            default: begin
               state_q <= IDLE;
               out_q   <= 1'b0;
               valid_q <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign out       = out_q;
   assign out_valid = valid_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_seq_gen.sv
// tb_seq_gen: directed checks of seq_gen with WIDTH=5, SEQ=10010, CNT_W=4
module tb_seq_gen;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic [3:0] repeat_n = '0;
   logic [3:0] gap = '0;
   logic       out, out_valid, busy, done;
   int         pass_cnt = 0;
   int         total_cnt = 0;
   logic [4:0] pat = 5'b10010;

   seq_gen dut (
      .clk(clk), .rst_n(rst_n), .start(start), .repeat_n(repeat_n), .gap(gap),
      .abort(abort), .out(out), .out_valid(out_valid), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic launch(input logic [3:0] r, input logic [3:0] g);
      start = 1'b1;
      repeat_n = r;
      gap = g;
      step();
      start = 1'b0;
   endtask

   task automatic test_reset();
      #12;
      total_cnt++;
      if ({out, out_valid, busy, done} !== 4'b0000)
         $display("FAIL reset got out/valid/busy/done=%b exp 0000", {out, out_valid, busy, done});
      else pass_cnt++;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_single();
      launch(4'd1, 4'd0);
      for (int i = 0; i < 5; i++) begin
         total_cnt++;
         if ({out_valid, busy, out} !== {2'b11, pat[4-i]})
            $display("FAIL single bit%0d got valid/busy/out=%b exp %b", i, {out_valid, busy, out}, {2'b11, pat[4-i]});
         else pass_cnt++;
         step();
      end
      total_cnt++;
      if ({done, busy, out_valid} !== 3'b100)
         $display("FAIL single_done got done/busy/valid=%b exp 100", {done, busy, out_valid});
      else pass_cnt++;
      step();
      total_cnt++;
      if (done !== 1'b0) $display("FAIL single_done_pulse got done=%b exp 0", done);
      else pass_cnt++;
   endtask

   task automatic test_repeat3();
      launch(4'd3, 4'd0);
      for (int i = 0; i < 15; i++) begin
         total_cnt++;
         if ({out_valid, busy, out, done} !== {2'b11, pat[4-(i%5)], 1'b0})
            $display("FAIL repeat3 bit%0d got valid/busy/out/done=%b exp %b", i, {out_valid, busy, out, done}, {2'b11, pat[4-(i%5)], 1'b0});
         else pass_cnt++;
         step();
      end
      total_cnt++;
      if ({done, busy, out_valid} !== 3'b100)
         $display("FAIL repeat3_done got done/busy/valid=%b exp 100", {done, busy, out_valid});
      else pass_cnt++;
      step();
      total_cnt++;
      if (done !== 1'b0) $display("FAIL repeat3_done_pulse got done=%b exp 0", done);
      else pass_cnt++;
   endtask

   task automatic test_gap();
      logic [2:0] exp;
      launch(4'd2, 4'd2);
      for (int i = 0; i < 12; i++) begin
         exp = (i < 5) ? {2'b11, pat[4-i]} : (i < 7) ? 3'b010 : {2'b11, pat[4-(i-7)]};
         total_cnt++;
         if ({out_valid, busy, out} !== exp)
            $display("FAIL gap cycle%0d got valid/busy/out=%b exp %b", i, {out_valid, busy, out}, exp);
         else pass_cnt++;
         step();
      end
      total_cnt++;
      if ({done, busy, out_valid} !== 3'b100)
         $display("FAIL gap_done got done/busy/valid=%b exp 100", {done, busy, out_valid});
      else pass_cnt++;
      step();
   endtask

   task automatic test_abort();
      launch(4'd3, 4'd0);
      step();
      step();
      total_cnt++;
      if ({out_valid, out} !== {1'b1, pat[2]})
         $display("FAIL abort_pre got valid/out=%b exp %b", {out_valid, out}, {1'b1, pat[2]});
      else pass_cnt++;
      abort = 1'b1;
      step();
      abort = 1'b0;
      total_cnt++;
      if ({out_valid, busy, done, out} !== 4'b0000)
         $display("FAIL abort_post got valid/busy/done/out=%b exp 0000", {out_valid, busy, done, out});
      else pass_cnt++;
      launch(4'd1, 4'd0);
      total_cnt++;
      if ({out_valid, out} !== 2'b11)
         $display("FAIL abort_restart got valid/out=%b exp 11", {out_valid, out});
      else pass_cnt++;
      for (int i = 1; i < 5; i++) begin
         step();
         total_cnt++;
         if ({out_valid, out} !== {1'b1, pat[4-i]})
            $display("FAIL abort_restart bit%0d got valid/out=%b exp %b", i, {out_valid, out}, {1'b1, pat[4-i]});
         else pass_cnt++;
      end
      step();
      total_cnt++;
      if (done !== 1'b1) $display("FAIL abort_restart_done got done=%b exp 1", done);
      else pass_cnt++;
      step();
      launch(4'd2, 4'd3);
      repeat (5) step();
      total_cnt++;
      if ({out_valid, busy} !== 2'b01)
         $display("FAIL abort_gap_pre got valid/busy=%b exp 01", {out_valid, busy});
      else pass_cnt++;
      abort = 1'b1;
      step();
      abort = 1'b0;
      total_cnt++;
      if ({out_valid, busy, done} !== 3'b000)
         $display("FAIL abort_gap_post got valid/busy/done=%b exp 000", {out_valid, busy, done});
      else pass_cnt++;
      step();
      total_cnt++;
      if ({out_valid, busy, done} !== 3'b000)
         $display("FAIL abort_gap_quiet got valid/busy/done=%b exp 000", {out_valid, busy, done});
      else pass_cnt++;
   endtask

   task automatic test_ignore();
      launch(4'd1, 4'd0);
      start = 1'b1;
      repeat_n = 4'd3;
      gap = 4'd5;
      for (int i = 0; i < 5; i++) begin
         if (i == 3) start = 1'b0;
         total_cnt++;
         if ({out_valid, busy, out} !== {2'b11, pat[4-i]})
            $display("FAIL ignore_busy bit%0d got valid/busy/out=%b exp %b", i, {out_valid, busy, out}, {2'b11, pat[4-i]});
         else pass_cnt++;
         step();
      end
      total_cnt++;
      if ({done, busy} !== 2'b10) $display("FAIL ignore_done got done/busy=%b exp 10", {done, busy});
      else pass_cnt++;
      step();
      total_cnt++;
      if ({done, busy, out_valid} !== 3'b000)
         $display("FAIL ignore_after got done/busy/valid=%b exp 000", {done, busy, out_valid});
      else pass_cnt++;
      start = 1'b1;
      repeat_n = 4'd0;
      for (int i = 0; i < 2; i++) begin
         step();
         total_cnt++;
         if ({busy, out_valid, done} !== 3'b000)
            $display("FAIL ignore_rep0 cycle%0d got busy/valid/done=%b exp 000", i, {busy, out_valid, done});
         else pass_cnt++;
      end
      repeat_n = 4'd1;
      abort = 1'b1;
      step();
      start = 1'b0;
      abort = 1'b0;
      total_cnt++;
      if ({busy, out_valid} !== 2'b00)
         $display("FAIL ignore_start_abort got busy/valid=%b exp 00", {busy, out_valid});
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      launch(4'd1, 4'd0);
      repeat (5) step();
      total_cnt++;
      if (done !== 1'b1) $display("FAIL b2b_done1 got done=%b exp 1", done);
      else pass_cnt++;
      launch(4'd1, 4'd0);
      total_cnt++;
      if ({out_valid, out, done} !== 3'b110)
         $display("FAIL b2b_restart got valid/out/done=%b exp 110", {out_valid, out, done});
      else pass_cnt++;
      repeat (5) step();
      total_cnt++;
      if (done !== 1'b1) $display("FAIL b2b_done2 got done=%b exp 1", done);
      else pass_cnt++;
      step();
   endtask

   task automatic test_max_repeat();
      int nv = 0;
      int bad = 0;
      launch(4'd15, 4'd0);
      for (int c = 0; c < 100 && done !== 1'b1; c++) begin
         if (out_valid) begin
            if (out !== pat[4-(nv%5)]) bad++;
            nv++;
         end
         step();
      end
      total_cnt++;
      if (done !== 1'b1) $display("FAIL max_rep_done got done=%b exp 1 (timeout)", done);
      else pass_cnt++;
      total_cnt++;
      if (nv != 75) $display("FAIL max_rep_count got %0d valid bits exp 75", nv);
      else pass_cnt++;
      total_cnt++;
      if (bad != 0) $display("FAIL max_rep_bits got %0d wrong bits exp 0", bad);
      else pass_cnt++;
      step();
   endtask

   task automatic test_loopback();
      logic [4:0] sr = '0;
      int hits = 0;
      int nv = 0;
      launch(4'd4, 4'd1);
      for (int c = 0; c < 60 && done !== 1'b1; c++) begin
         if (out_valid) begin
            sr = {sr[3:0], out};
            nv++;
            if (sr == pat) hits++;
         end
         step();
      end
      total_cnt++;
      if (done !== 1'b1) $display("FAIL loop_done got done=%b exp 1 (timeout)", done);
      else pass_cnt++;
      total_cnt++;
      if (hits != 4) $display("FAIL loop_hits got %0d exp 4", hits);
      else pass_cnt++;
      total_cnt++;
      if (nv != 20) $display("FAIL loop_bits got %0d exp 20", nv);
      else pass_cnt++;
      step();
   endtask

   task automatic test_reset_mid();
      launch(4'd3, 4'd0);
      step();
      step();
      #2 rst_n = 1'b0;
      #1;
      total_cnt++;
      if ({out, out_valid, busy, done} !== 4'b0000)
         $display("FAIL rst_mid got out/valid/busy/done=%b exp 0000", {out, out_valid, busy, done});
      else pass_cnt++;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         total_cnt++;
         if ({busy, out_valid, done} !== 3'b000)
            $display("FAIL rst_after cycle%0d got busy/valid/done=%b exp 000", i, {busy, out_valid, done});
         else pass_cnt++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_single();
      test_repeat3();
      test_gap();
      test_abort();
      test_ignore();
      test_back_to_back();
      test_max_repeat();
      test_loopback();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/seq_gen.md
SEQ_GEN -- requirements
Module: seq_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 5, pattern length in bits (WIDTH >= 2).
REQ-002 SHALL have parameter SEQ [WIDTH-1:0], default 5'b10010, pattern transmitted MSB first.
REQ-003 SHALL have parameter CNT_W, default 4, width of the repeat and gap fields.
REQ-004 clk  input  1  clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  request to begin a burst; sampled only in IDLE.
REQ-007 repeat_n  input  CNT_W  number of pattern repetitions per burst; latched on accepted start.
REQ-008 gap  input  CNT_W  idle cycles between repetitions; latched on accepted start.
REQ-009 abort  input  1  terminate the burst immediately.
REQ-010 out  output  1  serial data bit, registered.
REQ-011 out_valid  output  1  out carries a pattern bit this cycle, registered.
REQ-012 busy  output  1  high while in SEND or GAP, registered.
REQ-013 done  output  1  one-cycle pulse on normal burst completion, registered.

Function
REQ-014 SHALL implement the states IDLE, SEND and GAP.
REQ-015 IDLE -> SEND when start=1, abort=0 and repeat_n!=0; SHALL latch repeat_n and gap and load bit index WIDTH-1.
REQ-016 start with repeat_n=0 SHALL be ignored: remain in IDLE, no busy, no done.
REQ-017 start in SEND or GAP SHALL be ignored; latched values SHALL NOT change.
REQ-018 Latency: start accepted at edge k -> out_valid=1, out=SEQ[WIDTH-1] in the cycle after edge k.
REQ-019 In SEND: out=SEQ[idx], out_valid=1; idx decrements by 1 each cycle from WIDTH-1 down to 0.
REQ-020 At idx=0 with repetitions remaining and latched gap=0: reload idx=WIDTH-1 and stay in SEND (back-to-back bits, no bubble).
REQ-021 At idx=0 with repetitions remaining and gap>0: enter GAP for exactly gap cycles with out=0, out_valid=0, busy=1; then SEND with idx=WIDTH-1.
REQ-022 At idx=0 of the last repetition: -> IDLE; done=1 for exactly the first IDLE cycle.
REQ-023 The repetition counter SHALL be CNT_W bits; repeat_n=2^CNT_W-1 SHALL produce exactly that many repetitions, with no wrap-around.
REQ-024 abort=1 in SEND or GAP SHALL cause the next cycle to be IDLE with out=0, out_valid=0, busy=0, done=0; abort has priority over every other transition.
REQ-025 abort=1 together with start in IDLE SHALL leave the block in IDLE.
REQ-026 Outside SEND: out=0, out_valid=0.
REQ-027 In IDLE the block SHALL accept a new start in the cycle done is high or in the cycle after an abort.

Reset
REQ-028 rst_n=0 SHALL asynchronously force IDLE, out=0, out_valid=0, busy=0, done=0, and clear counters and latched fields.
REQ-029 Reset asserted mid-burst SHALL discard the burst; no done after release.
REQ-030 The first start SHALL be accepted at the first rising edge after rst_n deasserts.

Structure
REQ-031 State encoding constants (IDLE, SEND, GAP) SHALL reside in the shared package seq_pkg, for reuse by the detector-side benches.
REQ-032 SHALL be a single module with no sub-module; bit-index, repetition and gap counters are inline.

Verification (WIDTH=5, SEQ=10010, CNT_W=4)
REQ-033 start, repeat_n=1, gap=0 -> out_valid high for 5 cycles; out=1,0,0,1,0; busy high for 5 cycles; done pulse in the 6th cycle.
REQ-034 repeat_n=3, gap=0 -> 15 contiguous valid bits (10010 x3), then a single done pulse.
REQ-035 repeat_n=2, gap=2 -> 5 valid bits, 2 cycles with out_valid=0 and busy=1, 5 valid bits, then done.
REQ-036 abort while the 3rd bit is driven -> out_valid=0 and busy=0 the next cycle, no done; a start in the following cycle begins a fresh pattern at SEQ[4].
REQ-037 start while busy, and start with repeat_n=0 in IDLE -> both ignored; output stream unchanged; no extra done.
REQ-038 Loopback: out gated by out_valid into the team's shift-register detector with the same SEQ, repeat_n=4, gap=1 -> detector output high exactly 4 times, once per repetition; rst_n pulsed mid-burst -> all outputs 0 immediately.
